// File: rtl/serial_sub_unit.sv
// Bit-serial two's-complement subtractor: D = A - B - BIN, one bit per clock, LSB first.
// One full-subtractor cell and a borrow flop iterate over right-shifting operand registers.
module serial_sub_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             dbg_state
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q, a_msb_q, b_msb_q;
    logic             busy_q, done_q, borrow_q, ovf_q;

    logic             d_bit;
    logic             br_d;
    logic [WIDTH-1:0] res_d;

    // Handshake: start is only sampled while busy=0; done pulses for one cycle and
    // diff/borrow/ovf hold their value from that cycle until the next completion.
    always_comb begin
        d_bit = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        br_d  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
        res_d = {d_bit, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    br_q   <= br_d;
                    res_q  <= res_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // The bit produced this edge is the result MSB.
                        diff_q   <= res_d;
                        borrow_q <= br_d;
                        ovf_q    <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule
